sram_array: RTL and testbench

- Parametrised word-organised SRAM array. Successor to the single-bit storage cell: generalised to WIDTH-bit words and DEPTH entries, with synchronous clocked access.
- Adds behaviour the bit cell lacks: registered read data with a valid strobe, detection of illegal access (read and write both high, or address out of range), and a hardware clear sweep.
- Sits below the memory-test top level and replaces the hand-built 8x8 byte-cell grid.

---
 rtl/sram_array.sv | 110 +++++++++++
 tb/tb_sram_array.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_array.sv
// sram_array: WIDTH x DEPTH word SRAM with registered read, valid/err
// strobes and a hardware clear sweep that runs after reset and on clr.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   addr   - word address
//   inp    - write data
//   we     - write enable
//   re     - read enable
//   clr    - start a clear sweep (from IDLE only)
//   outp   - registered read data, holds when valid=0
//   valid  - one-cycle pulse, outp updated by a read
//   busy   - clear sweep in progress, accesses dropped
//   err    - one-cycle pulse, illegal access rejected
module sram_array #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  inp,
    input  logic              we,
    input  logic              re,
    input  logic              clr,
    output logic [WIDTH-1:0]  outp,
    output logic              valid,
    output logic              busy,
    output logic              err
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    // Extra bit so DEPTH == 2^ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic in_range;
    logic acc_ok;
    logic wr_ok;
    logic rd_ok;
    logic bad;

    assign in_range = {1'b0, addr} < DEPTH_X;
    // A clr edge in IDLE starts the sweep and performs no access.
    assign acc_ok   = (state == IDLE) & ~clr;
    assign wr_ok    = acc_ok & we & ~re & in_range;
    assign rd_ok    = acc_ok & re & ~we & in_range;
    assign bad      = acc_ok & (we | re) & ((we & re) | ~in_range);

    // Storage has no reset; the sweep defines its contents.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[ptr] <= '0;
        end else if (wr_ok) begin
            mem[addr] <= inp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
            outp  <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            valid <= rd_ok;
            err   <= bad;
            if (rd_ok) begin
                outp <= mem[addr];
            end
            unique case (state)
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // The edge that clears the last word also leaves CLEAR.
                    if (ptr == LAST) begin
                        state <= IDLE;
                        ptr   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                    ptr   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_array.sv
// tb_sram_array: drives a DEPTH=8 and a DEPTH=6 instance with the same
// directed vectors and checks both against a word-level model.
module tb_sram_array;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] addr  = '0;
    logic [7:0] inp   = '0;
    logic       we    = 1'b0;
    logic       re    = 1'b0;
    logic       clr   = 1'b0;

    logic [7:0] outp8, outp6;
    logic       valid8, valid6, busy8, busy6, err8, err6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_array #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) u8 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .inp(inp),
        .we(we), .re(re), .clr(clr),
        .outp(outp8), .valid(valid8), .busy(busy8), .err(err8)
    );

    sram_array #(.WIDTH(8), .DEPTH(6), .ADDR_W(3)) u6 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .inp(inp),
        .we(we), .re(re), .clr(clr),
        .outp(outp6), .valid(valid6), .busy(busy6), .err(err6)
    );

    // Model: index 0 is the DEPTH=8 instance, index 1 the DEPTH=6 one.
    int         dep [2] = '{8, 6};
    logic [7:0] m_mem [2][8];
    int         m_busy [2];
    logic [7:0] m_outp [2];
    logic       m_valid [2];
    logic       m_err [2];

    function automatic void m_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k]  = dep[k];
            m_outp[k]  = '0;
            m_valid[k] = 1'b0;
            m_err[k]   = 1'b0;
            for (int j = 0; j < 8; j++) m_mem[k][j] = '0;
        end
    endfunction

    function automatic void m_step();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            m_err[k]   = 1'b0;
            if (m_busy[k] > 0) begin
                m_busy[k]--;
            end else if (clr) begin
                m_busy[k] = dep[k];
                for (int j = 0; j < 8; j++) m_mem[k][j] = '0;
            end else if (we && re) begin
                m_err[k] = 1'b1;
            end else if ((we || re) && int'(addr) >= dep[k]) begin
                m_err[k] = 1'b1;
            end else if (we) begin
                m_mem[k][addr] = inp;
            end else if (re) begin
                m_outp[k]  = m_mem[k][addr];
                m_valid[k] = 1'b1;
            end
        end
    endfunction

    always @(negedge rst_n) m_reset();

    always @(posedge clk) begin
        if (rst_n) m_step();
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("outp8", 32'(outp8), 32'(m_outp[0]));
        chk("valid8", 32'(valid8), 32'(m_valid[0]));
        chk("err8", 32'(err8), 32'(m_err[0]));
        chk("busy8", 32'(busy8), 32'(m_busy[0] != 0));
        chk("outp6", 32'(outp6), 32'(m_outp[1]));
        chk("valid6", 32'(valid6), 32'(m_valid[1]));
        chk("err6", 32'(err6), 32'(m_err[1]));
        chk("busy6", 32'(busy6), 32'(m_busy[1] != 0));
    end

    task automatic cyc(input logic w, input logic r, input logic c,
                       input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        we   = w;
        re   = r;
        clr  = c;
        addr = a;
        inp  = d;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (busy8 && n < 20) begin
            n++;
            idle();
        end
        chk(name, 32'(n), 32'd8);
    endtask

    task automatic read_all();
        for (int a = 0; a < 8; a++) cyc(1'b0, 1'b1, 1'b0, 3'(a), 8'h00);
        idle();
    endtask

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy8), 32'd1);
        chk("rst_outp", 32'(outp8), 32'd0);
        rst_n = 1'b1;
        count_busy("busy_after_reset");
        read_all();

        cyc(1'b1, 1'b0, 1'b0, 3'd3, 8'hA5);
        cyc(1'b0, 1'b1, 1'b0, 3'd3, 8'h00);
        idle();
        chk("rd3_outp", 32'(outp8), 32'hA5);
        chk("rd3_valid", 32'(valid8), 32'd1);
        idle();
        chk("valid_pulse", 32'(valid8), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 3'd4, 8'h00);
        idle();
        chk("rd4_outp", 32'(outp8), 32'h00);

        cyc(1'b1, 1'b0, 1'b0, 3'd2, 8'h3C);
        cyc(1'b1, 1'b1, 1'b0, 3'd2, 8'hEE);
        idle();
        chk("both_err", 32'(err8), 32'd1);
        chk("both_valid", 32'(valid8), 32'd0);
        chk("both_outp", 32'(outp8), 32'h00);
        cyc(1'b0, 1'b1, 1'b0, 3'd2, 8'h00);
        idle();
        chk("rd2_outp", 32'(outp8), 32'h3C);

        cyc(1'b1, 1'b0, 1'b0, 3'd6, 8'hFF);
        idle();
        chk("wr6_err6", 32'(err6), 32'd1);
        chk("wr6_err8", 32'(err8), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 3'd6, 8'h00);
        idle();
        chk("rd6_err6", 32'(err6), 32'd1);
        chk("rd6_valid6", 32'(valid6), 32'd0);
        chk("rd6_outp8", 32'(outp8), 32'hFF);
        read_all();

        for (int a = 0; a < 8; a++)
            cyc(1'b1, 1'b0, 1'b0, 3'(a), 8'(8'h11 * (a + 1)));
        read_all();
        cyc(1'b0, 1'b1, 1'b0, 3'd7, 8'h00);
        idle();
        chk("rd7_fill", 32'(outp8), 32'h88);
        cyc(1'b1, 1'b1, 1'b1, 3'd0, 8'h55);
        cyc(1'b1, 1'b0, 1'b0, 3'd1, 8'h99);
        chk("clr_busy", 32'(busy8), 32'd1);
        chk("clr_no_err", 32'(err8), 32'd0);
        count_busy("busy_after_clr");
        read_all();
        cyc(1'b0, 1'b1, 1'b0, 3'd1, 8'h00);
        idle();
        chk("rd1_cleared", 32'(outp8), 32'h00);

        cyc(1'b1, 1'b0, 1'b0, 3'd5, 8'h77);
        cyc(1'b0, 1'b1, 1'b0, 3'd5, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
        chk("rd5_outp", 32'(outp8), 32'h77);
        idle();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_outp", 32'(outp8), 32'h00);
        chk("midrst_busy", 32'(busy8), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_busy("busy_after_midrst");
        read_all();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
